// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states and
// constants used by the top and the mul/div timer.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN = 1'b0,
        MD  = 1'b1
    } state_e;

    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam int unsigned MD_LAT_DEF = 8;

endpackage

// File: rtl/md_timer.sv
// Loadable down-counter timing the mul/div occupancy of EX.
// last is high while the counter holds 1, i.e. the final stalled cycle.
module md_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = MD_LAT_DEF
) (
    input  logic clk,
    input  logic Rst_n,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam logic [7:0] LOAD_VAL = 8'(MD_LAT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == 8'd1);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: load-use, taken branch in EX,
// and multi-cycle mul/div occupancy of EX, plus a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = MD_LAT_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_md,
    input  logic             br_taken_ex,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             exmem_flush,
    output logic             memwb_we,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e           state_q, state_d;
    logic             md_done_q, md_done_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic md_start;
    logic md_stall;
    logic md_last;

    assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

    // md_done marks the release cycle; it must not retrigger on the same ex_md.
    assign md_start = (state_q == RUN) && ex_md && !md_done_q;
    assign md_stall = md_start || (state_q == MD);

    md_timer #(
        .MD_LAT (MD_LAT)
    ) u_md_timer (
        .clk   (clk),
        .Rst_n (Rst_n),
        .load  (md_start),
        .dec   (state_q == MD),
        .last  (md_last)
    );

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_flush  = 1'b0;
        exmem_we    = 1'b1;
        exmem_flush = 1'b0;
        memwb_we    = 1'b1;
        if (md_stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
        end else if (br_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        md_done_d = 1'b0;
        unique case (state_q)
            RUN: if (md_start) state_d = MD;
            MD: begin
                if (md_last) begin
                    state_d   = RUN;
                    md_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= RUN;
            md_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_done_q   <= md_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy   = (state_q == MD);
    assign md_done   = md_done_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with MD_LAT=8.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_we}
    localparam logic [7:0] C_NORM = 8'b1101_0101;
    localparam logic [7:0] C_LU   = 8'b0001_1101;
    localparam logic [7:0] C_BR   = 8'b1111_1101;
    localparam logic [7:0] C_MD   = 8'b0000_0111;

    logic             clk = 1'b0;
    logic             Rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_md, br_taken_ex;
    logic             pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
    logic             exmem_we, exmem_flush, memwb_we, md_busy, md_done;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MD_LAT (8),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .Rst_n       (Rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_md       (ex_md),
        .br_taken_ex (br_taken_ex),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_we     (idex_we),
        .idex_flush  (idex_flush),
        .exmem_we    (exmem_we),
        .exmem_flush (exmem_flush),
        .memwb_we    (memwb_we),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [7:0] exp);
        check(tag, 32'({pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
                        exmem_we, exmem_flush, memwb_we}), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_md = 1'b0; br_taken_ex = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0;
        idle_inputs();
        #2;
        chk_ctrl("rst_ctrl", C_NORM);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_done", 32'(md_done), 32'd0);
        step();
        step();
        Rst_n = 1'b1;
        step();
        chk_ctrl("idle_ctrl", C_NORM);
        check("idle_cnt", 32'(stall_cnt), 32'd0);

        // Load-use on rs2
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        #2 chk_ctrl("lu_rs2", C_LU);
        step();
        idle_inputs();
        #2 check("lu_cnt", 32'(stall_cnt), 32'd1);
        chk_ctrl("lu_after", C_NORM);

        // Matching x0 is never a hazard
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
        #2 chk_ctrl("lu_x0", C_NORM);
        step();
        check("lu_x0_cnt", 32'(stall_cnt), 32'd1);

        // Load-use on rs1, then same regs without use_rs1
        idle_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        #2 chk_ctrl("lu_rs1", C_LU);
        step();
        check("lu_rs1_cnt", 32'(stall_cnt), 32'd2);
        id_use_rs1 = 1'b0;
        #2 chk_ctrl("lu_nouse", C_NORM);
        step();

        // Branch beats load-use
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1; br_taken_ex = 1'b1;
        #2 chk_ctrl("br_lu", C_BR);
        step();
        idle_inputs();
        check("br_cnt", 32'(stall_cnt), 32'd2);

        // Mul/div held: 8 stall cycles, release with md_done, no restart
        ex_md = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2 chk_ctrl($sformatf("md_ctrl%0d", i), C_MD);
            check($sformatf("md_busy%0d", i), 32'(md_busy), (i == 0) ? 32'd0 : 32'd1);
            check($sformatf("md_done%0d", i), 32'(md_done), 32'd0);
            step();
        end
        #2 check("md_rel_done", 32'(md_done), 32'd1);
        chk_ctrl("md_rel_ctrl", C_NORM);
        check("md_rel_busy", 32'(md_busy), 32'd0);
        check("md_rel_cnt", 32'(stall_cnt), 32'd10);
        ex_md = 1'b0;
        step();
        check("md_done_clr", 32'(md_done), 32'd0);
        check("md_cnt_hold", 32'(stall_cnt), 32'd10);

        // Branch during MD is ignored
        ex_md = 1'b1;
        for (int i = 0; i < 8; i++) begin
            br_taken_ex = (i == 3);
            #2 chk_ctrl($sformatf("mdbr_ctrl%0d", i), C_MD);
            step();
        end
        br_taken_ex = 1'b0;
        #2 check("mdbr_done", 32'(md_done), 32'd1);
        chk_ctrl("mdbr_rel", C_NORM);
        check("mdbr_cnt", 32'(stall_cnt), 32'd18);
        ex_md = 1'b0;
        step();

        // Reset in the middle of MD
        ex_md = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("mid_busy_pre", 32'(md_busy), 32'd1);
        Rst_n = 1'b0;
        ex_md = 1'b0;
        #1;
        check("mid_busy", 32'(md_busy), 32'd0);
        check("mid_cnt", 32'(stall_cnt), 32'd0);
        chk_ctrl("mid_ctrl", C_NORM);
        step();
        Rst_n = 1'b1;
        step();
        check("mid_done0", 32'(md_done), 32'd0);
        chk_ctrl("mid_post", C_NORM);
        step();
        check("mid_done1", 32'(md_done), 32'd0);
        check("mid_cnt_post", 32'(stall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush generator for the 5-stage pipeline. Drives the write_enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. Covers three cases: load-use hazards, taken-branch redirect in EX, and multi-cycle mul/div occupancy of EX. Holds the mul/div occupancy FSM and a stall performance counter.

Parameters:
MD_LAT, 8, total stall cycles for a mul/div in EX (legal range 2..255)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  pipeline clock; FSM and counters update on posedge, pipeline registers sample on negedge
Rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  source reg 1 of instruction in ID
id_rs2  in  5  source reg 2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination reg of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_md  in  1  EX instruction is mul/div
br_taken_ex  in  1  branch/jump resolved taken in EX
pc_we  out  1  PC write enable
ifid_we, ifid_flush  out  1,1  IF/ID controls
idex_we, idex_flush  out  1,1  ID/EX controls
exmem_we, exmem_flush  out  1,1  EX/MEM controls
memwb_we  out  1  MEM/WB write enable
md_busy  out  1  FSM in MD state
md_done  out  1  one-cycle pulse: mul/div result valid, EX releases
stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0

Behaviour:
- Single clock domain. Rst_n is asynchronous active-low. Under reset: state=RUN, md counter=0, md_done=0, stall_cnt=0.
- Control outputs are combinational from state and inputs, and must settle before the negedge. With inputs idle in RUN: all *_we=1, all *_flush=0.
- A flush is only meaningful with its we=1, because the downstream register ignores flush when we=0. Every flush this block asserts therefore comes with we=1.
- load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority in RUN, highest first:
  1. md_start = ex_md & !md_done: pc_we=ifid_we=idex_we=0; exmem_we=1, exmem_flush=1 (bubble into MEM); memwb_we=1. Load counter with MD_LAT-1 and go to MD.
  2. br_taken_ex: pc_we=1 (redirect); ifid_we=1, ifid_flush=1; idex_we=1, idex_flush=1; exmem_we=memwb_we=1. Overrides load_use.
  3. load_use: pc_we=0, ifid_we=0; idex_we=1, idex_flush=1 (one bubble); exmem_we=memwb_we=1. This is a one-cycle stall with no state change; the next cycle re-evaluates.
  4. Otherwise: normal advance.
- MD state: same outputs as md_start. br_taken_ex and load_use are ignored. Counter decrements each cycle; when counter==1, the next state is RUN and md_done is set for that one cycle.
- Total stalled cycles per mul/div = MD_LAT.
- In the md_done cycle, ex_md may still be high; md_done suppresses a restart. The instruction advances that cycle and md_done clears the following cycle.
- Back-to-back mul/div: the second instruction reaches EX after the first releases and starts a fresh MD_LAT stall.
- stall_cnt increments on every posedge with pc_we=0 and saturates at all-ones.
- Reset asserted mid-MD: immediate return to RUN, counter cleared, no md_done pulse.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, MD};
  - REG_ZERO = 5'd0;
  - MD_LAT default.
- One sub-module, md_timer: a loadable down-counter with a terminal flag, parameterised by MD_LAT.
- Hazard compare and output muxing stay in the top module.

Test Plan:
- Reset/idle: Rst_n=0 then 1, all inputs 0 -> all we=1, flushes 0, stall_cnt=0, md_busy=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1 that cycle; stall_cnt=1. Same case with ex_rd=0 -> no stall.
- Branch beats load-use: br_taken_ex=1 together with the load-use condition -> pc_we=1, ifid_flush=1, idex_flush=1, stall_cnt unchanged.
- Mul/div, MD_LAT=8: ex_md=1 held -> pc_we=0 for exactly 8 cycles, exmem_flush=1 in each; md_done=1 on the 9th cycle with pc_we=1; no restart; stall_cnt=8.
- Mul/div with branch during MD: br_taken_ex pulsed at MD cycle 3 -> ignored, stall length still 8.
- Reset mid-MD: Rst_n=0 at MD cycle 4 -> md_busy=0 immediately; after release, normal advance with no md_done pulse.
